// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad front end of the countdown timer.
// Consumed by keypad_encoder and keypad_sync.
package keypad_pkg;

  localparam int unsigned KP_KEYS             = 10;
  localparam int unsigned KP_DEBOUNCE_DEFAULT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StFire,
    StHeld,
    StRel
  } kp_state_t;

  // Number of pressed keys; 4 bits covers the full 0..10 range.
  function automatic logic [3:0] kp_popcount(input logic [KP_KEYS-1:0] vec);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      cnt = cnt + {3'b000, vec[i]};
    end
    return cnt;
  endfunction

  // Index of the set bit. Only meaningful when exactly one bit is set.
  function automatic logic [3:0] kp_onehot_to_bcd(input logic [KP_KEYS-1:0] vec);
    logic [3:0] bcd;
    bcd = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (vec[i]) begin
        bcd = 4'(i);
      end
    end
    return bcd;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low clear.
// Brings the raw keypad lines into the clk domain.
module keypad_sync #(
  parameter int unsigned Width = 10
) (
  input  logic             i_clk,
  input  logic             i_clrn,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to BCD encoder with a one-cycle active-low load strobe.
// Optional multi_err output is enabled by defining KEYPAD_MULTIKEY_ERR_EN.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [KP_KEYS-1:0] keypad,
  output logic [3:0]         code,
  output logic               loadn,
`ifdef KEYPAD_MULTIKEY_ERR_EN
  output logic               key_active,
  output logic               multi_err
`else
  output logic               key_active
`endif
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Synchronised key vector and its decode
  logic [KP_KEYS-1:0] w_ks;
  logic [3:0]         w_ks_pop;
  logic [3:0]         w_ks_code;
  logic               w_ks_single;
  logic               w_ks_multi;
  logic               w_ks_zero;

  // FSM state and captured press
  kp_state_t          r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [KP_KEYS-1:0] r_cap, w_cap_d;
  logic [3:0]         r_cap_code, w_cap_code_d;

  // Registered outputs
  logic [3:0]         r_code, w_code_d;
  logic               r_loadn, w_loadn_d;
  logic               r_key_active, w_key_active_d;

  keypad_sync #(
    .Width (KP_KEYS)
  ) u_sync (
    .i_clk  (clk),
    .i_clrn (clrn),
    .i_d    (keypad),
    .o_q    (w_ks)
  );

  assign w_ks_pop    = kp_popcount(w_ks);
  assign w_ks_code   = kp_onehot_to_bcd(w_ks);
  assign w_ks_single = (w_ks_pop == 4'd1);
  assign w_ks_multi  = (w_ks_pop > 4'd1);
  assign w_ks_zero   = (w_ks_pop == 4'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_cap      <= '0;
      r_cap_code <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_cap      <= w_cap_d;
      r_cap_code <= w_cap_code_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_cap_d      = r_cap;
    w_cap_code_d = r_cap_code;
    case (r_state)
      StIdle: begin
        // Zero or several keys: wait here without qualifying anything.
        if (w_ks_single) begin
          w_cap_d      = w_ks;
          w_cap_code_d = w_ks_code;
          w_cnt_d      = '0;
          w_state_d    = StDebounce;
        end
      end
      StDebounce: begin
        if (w_ks != r_cap) begin
          w_state_d = StIdle;
        end else if (r_cnt == CntMax) begin
          w_state_d = StFire;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      StFire: begin
        w_state_d = StHeld;
      end
      StHeld: begin
        // Rolled-over or added keys are ignored until everything is released.
        if (w_ks_zero) begin
          w_cnt_d   = '0;
          w_state_d = StRel;
        end
      end
      StRel: begin
        if (!w_ks_zero) begin
          w_state_d = StHeld;
        end else if (r_cnt == CntMax) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    w_code_d       = r_code;
    w_loadn_d      = 1'b1;
    w_key_active_d = (w_state_d != StIdle);
    if (w_state_d == StFire) begin
      w_code_d  = r_cap_code;
      w_loadn_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_code       <= '0;
      r_loadn      <= 1'b1;
      r_key_active <= 1'b0;
    end else begin
      r_code       <= w_code_d;
      r_loadn      <= w_loadn_d;
      r_key_active <= w_key_active_d;
    end
  end

  assign code       = r_code;
  assign loadn      = r_loadn;
  assign key_active = r_key_active;

`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic r_multi_err, w_multi_err_d;

  always_comb begin
    w_multi_err_d = r_multi_err;
    if (r_state == StIdle && w_ks_multi) begin
      w_multi_err_d = 1'b1;
    end else if (w_state_d == StFire) begin
      w_multi_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_multi_err <= 1'b0;
    end else begin
      r_multi_err <= w_multi_err_d;
    end
  end

  assign multi_err = r_multi_err;
`else
  logic w_unused_multi;
  assign w_unused_multi = w_ks_multi;
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed self-checking bench for keypad_encoder at DEBOUNCE_CYCLES = 4.
// multi_err checks are included when KEYPAD_MULTIKEY_ERR_EN is defined.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       clrn;
  logic [9:0] keypad;
  logic [3:0] code;
  logic       loadn;
  logic       key_active;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic       multi_err;
`endif

  int         errors  = 0;
  int         checks  = 0;
  int         strobes = 0;
  int         s0;
  logic [3:0] codes[$];

  keypad_encoder #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .keypad     (keypad),
    .code       (code),
    .loadn      (loadn),
`ifdef KEYPAD_MULTIKEY_ERR_EN
    .key_active (key_active),
    .multi_err  (multi_err)
`else
    .key_active (key_active)
`endif
  );

  always #5 clk = ~clk;

  // Strobe log, sampled on the falling edge
  always @(negedge clk) begin
    if (clrn === 1'b1 && loadn === 1'b0) begin
      strobes++;
      codes.push_back(code);
    end
  end

  // n rising edges; returns 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    keypad = '0;
    step(2);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL rst_loadn got=%b exp=1", loadn); end
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL rst_code got=%0d exp=0", code); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", key_active); end
`ifdef KEYPAD_MULTIKEY_ERR_EN
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL rst_multi got=%b exp=0", multi_err); end
`endif
    clrn = 1'b1;
    step(2);
    keypad = 10'b0000100000;
    step(3);
    checks++; if (key_active !== 1'b1) begin errors++; $display("FAIL deb_active got=%b exp=1", key_active); end
    step(2);
    clrn = 1'b0;
    #1;
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL midrst_loadn got=%b exp=1", loadn); end
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL midrst_code got=%0d exp=0", code); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL midrst_active got=%b exp=0", key_active); end
    s0 = strobes;
    step(1);
    clrn = 1'b1;
    step(6);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL rst_early got=%b exp=1", loadn); end
    step(1);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL rst_fire got=%b exp=0", loadn); end
    checks++; if (code !== 4'd5) begin errors++; $display("FAIL rst_code5 got=%0d exp=5", code); end
    step(1);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL rst_onecyc got=%b exp=1", loadn); end
    keypad = '0;
    step(15);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL rst_count got=%0d exp=1", strobes - s0); end
  endtask

  task automatic test_reset_fire;
    keypad = 10'b0001000000;
    step(7);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL rf_fire got=%b exp=0", loadn); end
    clrn = 1'b0;
    #1;
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL rf_loadn got=%b exp=1", loadn); end
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL rf_code got=%0d exp=0", code); end
    keypad = '0;
    s0 = strobes;
    step(2);
    clrn = 1'b1;
    step(15);
    checks++; if (strobes !== s0) begin errors++; $display("FAIL rf_count got=%0d exp=%0d", strobes, s0); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL rf_active got=%b exp=0", key_active); end
  endtask

  task automatic test_clean_press;
    s0 = strobes;
    keypad = 10'b0000001000;
    step(2);
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL cp_act2 got=%b exp=0", key_active); end
    step(1);
    checks++; if (key_active !== 1'b1) begin errors++; $display("FAIL cp_act3 got=%b exp=1", key_active); end
    step(3);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL cp_early got=%b exp=1", loadn); end
    step(1);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL cp_fire got=%b exp=0", loadn); end
    checks++; if (code !== 4'd3) begin errors++; $display("FAIL cp_code got=%0d exp=3", code); end
    step(1);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL cp_onecyc got=%b exp=1", loadn); end
    step(12);
    keypad = '0;
    step(15);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL cp_count got=%0d exp=1", strobes - s0); end
    checks++; if (code !== 4'd3) begin errors++; $display("FAIL cp_hold got=%0d exp=3", code); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL cp_idle got=%b exp=0", key_active); end
  endtask

  task automatic test_bounce;
    s0 = strobes;
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? 10'b0010000000 : 10'b0000000000;
      step(1);
    end
    checks++; if (strobes !== s0) begin errors++; $display("FAIL bn_quiet got=%0d exp=%0d", strobes, s0); end
    keypad = 10'b0010000000;
    step(6);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL bn_early got=%b exp=1", loadn); end
    step(1);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL bn_fire got=%b exp=0", loadn); end
    checks++; if (code !== 4'd7) begin errors++; $display("FAIL bn_code got=%0d exp=7", code); end
    step(1);
    keypad = '0;
    step(15);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL bn_count got=%0d exp=1", strobes - s0); end
  endtask

  task automatic test_multi_key;
    s0 = strobes;
    keypad = 10'b0100000100;
    step(2);
`ifdef KEYPAD_MULTIKEY_ERR_EN
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL mk_err2 got=%b exp=0", multi_err); end
`endif
    step(1);
`ifdef KEYPAD_MULTIKEY_ERR_EN
    checks++; if (multi_err !== 1'b1) begin errors++; $display("FAIL mk_err3 got=%b exp=1", multi_err); end
`endif
    step(27);
    checks++; if (strobes !== s0) begin errors++; $display("FAIL mk_quiet got=%0d exp=%0d", strobes, s0); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL mk_active got=%b exp=0", key_active); end
    keypad = 10'b0000010000;
    step(6);
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL mk_early got=%b exp=1", loadn); end
`ifdef KEYPAD_MULTIKEY_ERR_EN
    checks++; if (multi_err !== 1'b1) begin errors++; $display("FAIL mk_errhold got=%b exp=1", multi_err); end
`endif
    step(1);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL mk_fire got=%b exp=0", loadn); end
    checks++; if (code !== 4'd4) begin errors++; $display("FAIL mk_code got=%0d exp=4", code); end
`ifdef KEYPAD_MULTIKEY_ERR_EN
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL mk_errclr got=%b exp=0", multi_err); end
`endif
    keypad = '0;
    step(15);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL mk_count got=%0d exp=1", strobes - s0); end
  endtask

  task automatic test_hold_roll;
    s0 = strobes;
    keypad = 10'b0000000010;
    step(7);
    checks++; if (loadn !== 1'b0) begin errors++; $display("FAIL hr_fire got=%b exp=0", loadn); end
    checks++; if (code !== 4'd1) begin errors++; $display("FAIL hr_code got=%0d exp=1", code); end
    step(3);
    keypad = 10'b1000000010;
    step(10);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL hr_roll got=%0d exp=1", strobes - s0); end
    checks++; if (key_active !== 1'b1) begin errors++; $display("FAIL hr_active got=%b exp=1", key_active); end
    keypad = '0;
    step(3);
    keypad = 10'b0000000010;
    step(2);
    keypad = '0;
    step(15);
    checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL hr_count got=%0d exp=1", strobes - s0); end
    checks++; if (code !== 4'd1) begin errors++; $display("FAIL hr_codehold got=%0d exp=1", code); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("FAIL hr_idle got=%b exp=0", key_active); end
  endtask

  task automatic test_sequence;
    int         keys[3];
    logic [3:0] got;
    keys = '{1, 3, 0};
    codes.delete();
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      keypad = 10'b0000000001 << keys[i];
      step(10);
      keypad = '0;
      step(15);
    end
    checks++; if (strobes - s0 !== 3) begin errors++; $display("FAIL sq_count got=%0d exp=3", strobes - s0); end
    for (int i = 0; i < 3; i++) begin
      got = (i < codes.size()) ? codes[i] : 4'bxxxx;
      checks++;
      if (got !== 4'(keys[i])) begin
        errors++;
        $display("FAIL sq_code%0d got=%0d exp=%0d", i, got, keys[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_fire();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_hold_roll();
    test_sequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
